// File: rtl/rrf_dispatch_ctrl_pkg.sv
// Shared constants and state encodings for the RRF dispatch controller.
package rrf_dispatch_ctrl_pkg;

    localparam int RRF_SEL         = 6;
    localparam int RRF_NUM         = 2 ** RRF_SEL;
    localparam int RECOVER_CYC_DEF = 2;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

endpackage

// File: rtl/rrf_dispatch_ctrl_hold.sv
// Single-entry buffer for a rename request pair {valid, inv1, inv2}.
// Clear wins over load so a flush always empties the entry.
module rrf_pair_hold
    import rrf_dispatch_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic load_inv1,
    input  logic load_inv2,
    output logic held_valid,
    output logic held_inv1,
    output logic held_inv2
);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            held_valid <= 1'b0;
            held_inv1  <= 1'b1;
            held_inv2  <= 1'b1;
        end else if (load) begin
            held_valid <= 1'b1;
            held_inv1  <= load_inv1;
            held_inv2  <= load_inv2;
        end
    end

endmodule

// File: rtl/rrf_dispatch_ctrl.sv
// Rename-register dispatch controller between decode and the RRF free list.
// Optional feature: define RRF_DISPATCH_STALLCNT_EN for a saturating stall counter.
module rrf_dispatch_ctrl
    import rrf_dispatch_ctrl_pkg::*;
#(
    parameter int RECOVER_CYC = RECOVER_CYC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dec_valid,
    input  logic               dec_inv1,
    input  logic               dec_inv2,
    output logic               dec_ready,
    input  logic               prmiss,
    input  logic               fl_allocatable,
    input  logic [RRF_SEL-1:0] fl_dst1,
    input  logic [RRF_SEL-1:0] fl_dst2,
    output logic               fl_invalid1,
    output logic               fl_invalid2,
    output logic               fl_stall,
    output logic               dp_valid,
    output logic               dp_inv1,
    output logic               dp_inv2,
    output logic [RRF_SEL-1:0] dp_dst1,
    output logic [RRF_SEL-1:0] dp_dst2,
`ifdef RRF_DISPATCH_STALLCNT_EN
    input  logic               stall_cnt_clr,
    output logic [15:0]        stall_cnt,
`endif
    output logic               busy
);

    localparam logic [2:0] RECOVER_LOAD = 3'(RECOVER_CYC - 1);

    state_t     state;
    logic [2:0] recover_cnt;

    logic held_valid, held_inv1, held_inv2;
    logic present_valid, present_inv1, present_inv2;
    logic fire, hold_load, hold_clear;

    // The free list sees either the live decode pair or the buffered one.
    always_comb begin
        present_valid = 1'b0;
        present_inv1  = 1'b1;
        present_inv2  = 1'b1;
        case (state)
            ST_RUN: begin
                present_valid = dec_valid;
                present_inv1  = dec_inv1;
                present_inv2  = dec_inv2;
            end
            ST_HOLD: begin
                present_valid = held_valid;
                present_inv1  = held_inv1;
                present_inv2  = held_inv2;
            end
            default: ;
        endcase
    end

    assign fl_invalid1 = ~present_valid | present_inv1;
    assign fl_invalid2 = ~present_valid | present_inv2;
    assign fl_stall    = present_valid & ~fl_allocatable & ~prmiss;
    assign fire        = present_valid & fl_allocatable & ~prmiss & (state != ST_RECOVER);
    assign dec_ready   = (state == ST_RUN) & ~prmiss;
    assign busy        = (state != ST_RUN);

    assign hold_load  = dec_valid & dec_ready & ~fire;
    assign hold_clear = prmiss | ((state == ST_HOLD) & fire);

    rrf_pair_hold u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (hold_load),
        .clear      (hold_clear),
        .load_inv1  (dec_inv1),
        .load_inv2  (dec_inv2),
        .held_valid (held_valid),
        .held_inv1  (held_inv1),
        .held_inv2  (held_inv2)
    );

    // prmiss overrides everything else and restarts the blackout window.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_RUN;
            recover_cnt <= 3'd0;
            dp_valid    <= 1'b0;
            dp_inv1     <= 1'b1;
            dp_inv2     <= 1'b1;
            dp_dst1     <= '0;
            dp_dst2     <= '0;
        end else begin
            dp_valid <= fire;
            if (fire) begin
                dp_inv1 <= present_inv1;
                dp_inv2 <= present_inv2;
                dp_dst1 <= fl_dst1;
                dp_dst2 <= fl_dst2;
            end
            if (prmiss) begin
                state       <= ST_RECOVER;
                recover_cnt <= RECOVER_LOAD;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (hold_load)
                            state <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (fire)
                            state <= ST_RUN;
                    end
                    ST_RECOVER: begin
                        if (recover_cnt == 3'd0)
                            state <= ST_RUN;
                        else
                            recover_cnt <= recover_cnt - 3'd1;
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

`ifdef RRF_DISPATCH_STALLCNT_EN
    always_ff @(posedge clk) begin
        if (!reset || stall_cnt_clr)
            stall_cnt <= 16'd0;
        else if (fl_stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_rrf_dispatch_ctrl.sv
// Directed scoreboard bench for rrf_dispatch_ctrl (RECOVER_CYC = 2, RRF_SEL = 6).
module tb_rrf_dispatch_ctrl;
    import rrf_dispatch_ctrl_pkg::*;

    typedef struct packed {
        logic               inv1;
        logic               inv2;
        logic [RRF_SEL-1:0] dst1;
        logic [RRF_SEL-1:0] dst2;
    } bundle_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic dec_valid = 1'b0, dec_inv1 = 1'b0, dec_inv2 = 1'b0;
    logic prmiss = 1'b0, fl_allocatable = 1'b0;
    logic [RRF_SEL-1:0] fl_dst1 = '0, fl_dst2 = '0;
    logic dec_ready, fl_invalid1, fl_invalid2, fl_stall;
    logic dp_valid, dp_inv1, dp_inv2, busy;
    logic [RRF_SEL-1:0] dp_dst1, dp_dst2;
`ifdef RRF_DISPATCH_STALLCNT_EN
    logic stall_cnt_clr = 1'b0;
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad = 0;
    bundle_t expq[$];

    always #5 clk = ~clk;

    rrf_dispatch_ctrl #(.RECOVER_CYC(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .dec_valid      (dec_valid),
        .dec_inv1       (dec_inv1),
        .dec_inv2       (dec_inv2),
        .dec_ready      (dec_ready),
        .prmiss         (prmiss),
        .fl_allocatable (fl_allocatable),
        .fl_dst1        (fl_dst1),
        .fl_dst2        (fl_dst2),
        .fl_invalid1    (fl_invalid1),
        .fl_invalid2    (fl_invalid2),
        .fl_stall       (fl_stall),
        .dp_valid       (dp_valid),
        .dp_inv1        (dp_inv1),
        .dp_inv2        (dp_inv2),
        .dp_dst1        (dp_dst1),
        .dp_dst2        (dp_dst2),
`ifdef RRF_DISPATCH_STALLCNT_EN
        .stall_cnt_clr  (stall_cnt_clr),
        .stall_cnt      (stall_cnt),
`endif
        .busy           (busy)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then settle to the falling edge.
    task automatic applyStimulus(input logic v, input logic i1, input logic i2, input logic alloc,
                                 input int d1, input int d2, input logic pm);
        @(posedge clk);
        #1;
        dec_valid      = v;
        dec_inv1       = i1;
        dec_inv2       = i2;
        fl_allocatable = alloc;
        fl_dst1        = RRF_SEL'(d1);
        fl_dst2        = RRF_SEL'(d2);
        prmiss         = pm;
        @(negedge clk);
    endtask

    task automatic expectBundle(input logic i1, input logic i2, input int d1, input int d2);
        bundle_t b;
        b.inv1 = i1;
        b.inv2 = i2;
        b.dst1 = RRF_SEL'(d1);
        b.dst2 = RRF_SEL'(d2);
        expq.push_back(b);
    endtask

    // Monitor: every dispatched bundle must match the oldest expected one.
    always @(negedge clk) begin
        if (reset === 1'b1 && dp_valid === 1'b1) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("[TB] FAIL dp_unexpected: got dst1=%0d dst2=%0d expected no bundle", dp_dst1, dp_dst2);
            end else begin
                bundle_t e;
                e = expq.pop_front();
                if ({dp_inv1, dp_inv2, dp_dst1, dp_dst2} !== e) begin
                    bad++;
                    $display("[TB] FAIL dp_bundle: got inv=%b%b dst=%0d/%0d expected inv=%b%b dst=%0d/%0d",
                             dp_inv1, dp_inv2, dp_dst1, dp_dst2, e.inv1, e.inv2, e.dst1, e.dst2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_dp_valid", 16'(dp_valid), 16'd0);
        checkOutput("rst_dp_inv", 16'({dp_inv1, dp_inv2}), 16'b11);
        checkOutput("rst_dp_dst", 16'({dp_dst1, dp_dst2}), 16'd0);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_dec_ready", 16'(dec_ready), 16'd1);
`ifdef RRF_DISPATCH_STALLCNT_EN
        checkOutput("rst_stall_cnt", stall_cnt, 16'd0);
`endif

        // Straight fire
        applyStimulus(1, 0, 0, 1, 5, 6, 0);
        expectBundle(0, 0, 5, 6);
        checkOutput("t1_fl_invalid", 16'({fl_invalid1, fl_invalid2}), 16'b00);
        checkOutput("t1_fl_stall", 16'(fl_stall), 16'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_dp_valid", 16'(dp_valid), 16'd1);
        checkOutput("t1_idle_invalid", 16'({fl_invalid1, fl_invalid2}), 16'b11);

        // Free list empty: accept into hold, stall, then drain
        applyStimulus(1, 0, 0, 0, 7, 8, 0);
        checkOutput("t2_stall_run", 16'(fl_stall), 16'd1);
        checkOutput("t2_ready_run", 16'(dec_ready), 16'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 7, 8, 0);
            checkOutput("t2_stall_hold", 16'(fl_stall), 16'd1);
            checkOutput("t2_ready_hold", 16'(dec_ready), 16'd0);
            checkOutput("t2_busy_hold", 16'(busy), 16'd1);
            checkOutput("t2_dp_hold", 16'(dp_valid), 16'd0);
        end
`ifdef RRF_DISPATCH_STALLCNT_EN
        checkOutput("sc_count", stall_cnt, 16'd3);
`endif
        applyStimulus(0, 0, 0, 1, 9, 10, 0);
        expectBundle(0, 0, 9, 10);
        checkOutput("t2_fire_stall", 16'(fl_stall), 16'd0);
        checkOutput("t2_fire_invalid", 16'({fl_invalid1, fl_invalid2}), 16'b00);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_dp_valid", 16'(dp_valid), 16'd1);
        checkOutput("t2_busy_run", 16'(busy), 16'd0);
        checkOutput("t2_ready_run2", 16'(dec_ready), 16'd1);
`ifdef RRF_DISPATCH_STALLCNT_EN
        checkOutput("sc_total", stall_cnt, 16'd4);
        @(posedge clk);
        #1 stall_cnt_clr = 1'b1;
        @(posedge clk);
        #1 stall_cnt_clr = 1'b0;
        @(negedge clk);
        checkOutput("sc_clear", stall_cnt, 16'd0);
`endif

        // prmiss during HOLD
        applyStimulus(1, 1, 0, 0, 1, 2, 0);
        checkOutput("t3_invalid_run", 16'({fl_invalid1, fl_invalid2}), 16'b10);
        applyStimulus(0, 0, 0, 0, 1, 2, 1);
        checkOutput("t3_busy_hold", 16'(busy), 16'd1);
        checkOutput("t3_stall_pm", 16'(fl_stall), 16'd0);
        checkOutput("t3_ready_pm", 16'(dec_ready), 16'd0);
        applyStimulus(0, 0, 0, 1, 1, 2, 0);
        checkOutput("t3_rec1_ready", 16'(dec_ready), 16'd0);
        checkOutput("t3_rec1_invalid", 16'({fl_invalid1, fl_invalid2}), 16'b11);
        checkOutput("t3_rec1_dp", 16'(dp_valid), 16'd0);
        applyStimulus(0, 0, 0, 1, 1, 2, 0);
        checkOutput("t3_rec2_ready", 16'(dec_ready), 16'd0);
        checkOutput("t3_rec2_busy", 16'(busy), 16'd1);
        applyStimulus(0, 0, 0, 1, 1, 2, 0);
        checkOutput("t3_run_ready", 16'(dec_ready), 16'd1);
        checkOutput("t3_run_invalid", 16'({fl_invalid1, fl_invalid2}), 16'b11);
        checkOutput("t3_run_dp", 16'(dp_valid), 16'd0);

        // Fire and prmiss together: prmiss wins
        applyStimulus(1, 0, 0, 1, 3, 4, 1);
        checkOutput("t4_ready_pm", 16'(dec_ready), 16'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_dp_valid", 16'(dp_valid), 16'd0);
        checkOutput("t4_busy", 16'(busy), 16'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_busy2", 16'(busy), 16'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_ready_back", 16'(dec_ready), 16'd1);

        // Both slots invalid still fires
        applyStimulus(1, 1, 1, 1, 11, 12, 0);
        expectBundle(1, 1, 11, 12);
        checkOutput("t5_fl_invalid", 16'({fl_invalid1, fl_invalid2}), 16'b11);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_dp_valid", 16'(dp_valid), 16'd1);

        // Reset in the middle of RECOVER
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_busy_rec", 16'(busy), 16'd1);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_busy", 16'(busy), 16'd0);
        checkOutput("t6_dp_valid", 16'(dp_valid), 16'd0);
        checkOutput("t6_ready", 16'(dec_ready), 16'd1);
`ifdef RRF_DISPATCH_STALLCNT_EN
        checkOutput("t6_stall_cnt", stall_cnt, 16'd0);
`endif

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 16'(expq.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rrf_dispatch_ctrl.md
Name: rrf_dispatch_ctrl

Overview:
- Sequences rename-register allocation between the decode stage and the RRF free-list manager.
- Accepts up to two rename requests per cycle through a valid/ready handshake and buffers one request pair while the free list cannot cover it.
- Drives the free-list manager's invalid1/invalid2/stall_DP inputs and enforces a fixed recovery blackout after a branch mispredict.
- Emits a registered dispatch bundle, with allocated tags, to the reservation-station stage.

Parameters:
- RRF_SEL, 6, tag width; RRF_NUM = 2**RRF_SEL entries.
- RECOVER_CYC, 2, cycles of allocation blackout after prmiss (valid range 1..7).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- dec_valid  in  1  decode offers a request pair
- dec_inv1  in  1  slot 1 needs no destination register
- dec_inv2  in  1  slot 2 needs no destination register
- dec_ready  out  1  controller can accept a pair this cycle
- prmiss  in  1  branch mispredict flush
- fl_allocatable  in  1  free list can satisfy the presented reqnum
- fl_dst1  in  RRF_SEL  tag for slot 1 from the free list
- fl_dst2  in  RRF_SEL  tag for slot 2 from the free list
- fl_invalid1  out  1  to free list: slot 1 not allocating
- fl_invalid2  out  1  to free list: slot 2 not allocating
- fl_stall  out  1  to free list stall_DP
- dp_valid  out  1  registered dispatch bundle valid
- dp_inv1  out  1  registered copy of the slot 1 invalid flag
- dp_inv2  out  1  registered copy of the slot 2 invalid flag
- dp_dst1  out  RRF_SEL  registered allocated tag for slot 1
- dp_dst2  out  RRF_SEL  registered allocated tag for slot 2
- busy  out  1  state != RUN

Behaviour:
- State machine, 2-bit encoding:
  - RUN: the incoming pair is presented directly.
  - HOLD: the buffered pair is presented.
  - RECOVER: no allocation.
- Presented pair:
  - In RUN: the dec_* pair, gated by dec_valid.
  - In HOLD: the held register pair.
- fl_invalid1/fl_invalid2 = ~present_valid | inv flag of the presented pair.
  - In RECOVER, or when nothing is presented, both are 1, so reqnum = 0.
- fl_stall = present_valid & ~fl_allocatable & ~prmiss. This is combinational and consistent with the free-list manager's stall_DP contract.
- fire = present_valid & fl_allocatable & ~prmiss & (state != RECOVER).
- dec_ready = (state == RUN) & ~prmiss.
  - A handshake (dec_valid & dec_ready) that does not fire loads the hold register and moves to HOLD.
- HOLD -> RUN on fire. dec_ready is 0 in HOLD, so no new pair is accepted on that cycle.
- prmiss in any state:
  - Clears the hold register and dp_valid on the next edge.
  - Loads the blackout counter with RECOVER_CYC-1.
  - Next state is RECOVER.
  - prmiss wins over a simultaneous fire or handshake.
- RECOVER:
  - Counter decrements each cycle; at 0 the next state is RUN.
  - A repeated prmiss reloads the counter.
  - dec_ready = 0.
- Latency: fire in cycle N -> dp_valid=1 in cycle N+1.
  - dp_dst1/dp_dst2 and dp_inv1/dp_inv2 are captured from fl_dst1/fl_dst2 and the presented flags in cycle N.
- Tag width is RRF_SEL. Wrap-around is owned by the free list; the controller passes tags unmodified.
- A pair with both slots invalid still fires (reqnum = 0, fl_allocatable = 1) and produces dp_valid.
- Reset (reset == 0 at an edge), including mid-HOLD or mid-RECOVER:
  - state = RUN, counter = 0, hold cleared.
  - dp_valid = 0, dp_inv1 = dp_inv2 = 1, dp_dst1 = dp_dst2 = 0.
  - dec_ready is 1 on the first cycle after reset release, with prmiss = 0.

Optional Feature:
- Macro: RRF_DISPATCH_STALLCNT_EN.
- Defined:
  - Adds output stall_cnt [15:0], a saturating count of cycles with fl_stall = 1.
  - Cleared on reset; holds at 16'hFFFF.
  - Adds input stall_cnt_clr, a synchronous clear with priority over increment.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Shared package / constants header:
  - RRF_SEL and RRF_NUM, reusing the existing constants include.
  - State encodings ST_RUN, ST_HOLD, ST_RECOVER.
- Sub-module rrf_pair_hold: single-entry register for {valid, inv1, inv2} with load/clear. It is small but keeps the FSM readable.

Test Plan:
- dec_valid=1, inv1=inv2=0, fl_allocatable=1, fl_dst1=5, fl_dst2=6 -> fl_invalid1/2=0; next cycle dp_valid=1, dp_dst1=5, dp_dst2=6.
- fl_allocatable=0 for 3 cycles with a pair offered -> HOLD, fl_stall=1 for 3 cycles, dec_ready=0; allocatable=1 -> dp_valid one cycle later, state RUN.
- prmiss pulse during HOLD, RECOVER_CYC=2 -> hold cleared, no dp_valid, dec_ready=0 for 2 cycles, then 1.
- Simultaneous fire and prmiss -> no dp_valid next cycle, state RECOVER.
- dec_inv1=1, dec_inv2=1, dec_valid=1 -> fl_invalid1/2=1, fires, dp_valid=1 with dp_inv1=dp_inv2=1.
- Reset asserted mid-RECOVER -> next cycle state RUN, dp_valid=0; with RRF_DISPATCH_STALLCNT_EN, stall_cnt=0.
